// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared Ascon-128 controller types and constants
package ascon_pack;

    localparam int ROUNDS_A_C = 12;
    localparam int ROUNDS_B_C = 6;
    localparam int ROUND_W_C  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT_AD,
        ST_AD_PERM,
        ST_WAIT_PT,
        ST_PT_PERM,
        ST_FINAL,
        ST_DONE
    } type_ctrl_state;

endpackage

// File: rtl/ascon_round_counter.sv
// rtl/ascon_round_counter.sv - permutation round index counter with load and last-round flag
module ascon_round_counter
    import ascon_pack::*;
#(
    parameter int ROUNDS_A = ROUNDS_A_C
) (
    input  logic                 clock_i,
    input  logic                 resetb_i,
    input  logic                 load_i,
    input  logic [ROUND_W_C-1:0] load_val_i,
    input  logic                 en_i,
    output logic [ROUND_W_C-1:0] rnd_o,
    output logic                 last_o
);

    localparam logic [ROUND_W_C-1:0] RND_LAST = ROUND_W_C'(ROUNDS_A - 1);

    logic [ROUND_W_C-1:0] rnd_q;

    // Load wins over increment so a new permutation can start on any cycle.
    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            rnd_q <= '0;
        end else if (load_i) begin
            rnd_q <= load_val_i;
        end else if (en_i) begin
            rnd_q <= rnd_q + ROUND_W_C'(1);
        end
    end

    assign rnd_o  = rnd_q;
    assign last_o = (rnd_q == RND_LAST);

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// rtl/ascon_ctrl_fsm.sv - Ascon-128 encryption sequencing controller
module ascon_ctrl_fsm
    import ascon_pack::*;
#(
    parameter int AD_BLOCKS = 1,
    parameter int PT_BLOCKS = 4,
    parameter int ROUNDS_A  = ROUNDS_A_C,
    parameter int ROUNDS_B  = ROUNDS_B_C
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic [3:0] round_o,
    output logic       en_reg_state_o,
    output logic       init_state_o,
    output logic       en_xor_data_o,
    output logic       en_xor_key_begin_o,
    output logic       en_xor_key_o,
    output logic       en_xor_lsb_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       done_o
);

    localparam int BLK_MAX = (AD_BLOCKS > PT_BLOCKS) ? AD_BLOCKS : PT_BLOCKS;
    localparam int BLK_W   = $clog2(BLK_MAX + 1);

    localparam logic [BLK_W-1:0]     AD_LAST = (AD_BLOCKS > 0) ? BLK_W'(AD_BLOCKS - 1) : '0;
    localparam logic [BLK_W-1:0]     PT_LAST = BLK_W'(PT_BLOCKS - 1);
    localparam logic [ROUND_W_C-1:0] RND_B0  = ROUND_W_C'(ROUNDS_A - ROUNDS_B);
    localparam logic [ROUND_W_C-1:0] RND_B1  = ROUND_W_C'(ROUNDS_A - ROUNDS_B + 1);

    type_ctrl_state       state_q, state_d;
    logic [BLK_W-1:0]     blk_q, blk_d;
    logic [ROUND_W_C-1:0] rnd_q;
    logic                 rnd_last;
    logic                 rnd_load;
    logic [ROUND_W_C-1:0] rnd_load_val;
    logic                 rnd_en;

    ascon_round_counter #(
        .ROUNDS_A (ROUNDS_A)
    ) u_round_counter (
        .clock_i    (clock_i),
        .resetb_i   (resetb_i),
        .load_i     (rnd_load),
        .load_val_i (rnd_load_val),
        .en_i       (rnd_en),
        .rnd_o      (rnd_q),
        .last_o     (rnd_last)
    );

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            state_q <= ST_IDLE;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        blk_d              = blk_q;
        rnd_load           = 1'b0;
        rnd_load_val       = '0;
        rnd_en             = 1'b0;
        data_ready_o       = 1'b0;
        round_o            = '0;
        en_reg_state_o     = 1'b0;
        init_state_o       = 1'b0;
        en_xor_data_o      = 1'b0;
        en_xor_key_begin_o = 1'b0;
        en_xor_key_o       = 1'b0;
        en_xor_lsb_o       = 1'b0;
        en_cipher_o        = 1'b0;
        en_tag_o           = 1'b0;
        done_o             = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                done_o = (state_q == ST_DONE);
                if (start_i) begin
                    state_d      = ST_INIT;
                    blk_d        = '0;
                    rnd_load     = 1'b1;
                    rnd_load_val = '0;
                end
            end

            ST_INIT: begin
                round_o        = rnd_q;
                en_reg_state_o = 1'b1;
                init_state_o   = (rnd_q == '0);
                rnd_en         = !rnd_last;
                if (rnd_last) begin
                    en_xor_key_o = 1'b1;
                    if (AD_BLOCKS == 0) begin
                        // No AD: domain separation folds into the init tail.
                        en_xor_lsb_o = 1'b1;
                        state_d      = ST_WAIT_PT;
                    end else begin
                        state_d = ST_WAIT_AD;
                    end
                end
            end

            ST_WAIT_AD: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    en_xor_data_o  = 1'b1;
                    en_reg_state_o = 1'b1;
                    round_o        = RND_B0;
                    rnd_load       = 1'b1;
                    rnd_load_val   = RND_B1;
                    state_d        = ST_AD_PERM;
                end
            end

            ST_AD_PERM: begin
                round_o        = rnd_q;
                en_reg_state_o = 1'b1;
                rnd_en         = !rnd_last;
                if (rnd_last) begin
                    if (blk_q == AD_LAST) begin
                        en_xor_lsb_o = 1'b1;
                        blk_d        = '0;
                        state_d      = ST_WAIT_PT;
                    end else begin
                        blk_d   = blk_q + BLK_W'(1);
                        state_d = ST_WAIT_AD;
                    end
                end
            end

            ST_WAIT_PT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    en_xor_data_o  = 1'b1;
                    en_cipher_o    = 1'b1;
                    en_reg_state_o = 1'b1;
                    rnd_load       = 1'b1;
                    if (blk_q == PT_LAST) begin
                        // Last block absorb doubles as the first finalisation round.
                        en_xor_key_begin_o = 1'b1;
                        round_o            = '0;
                        rnd_load_val       = ROUND_W_C'(1);
                        state_d            = ST_FINAL;
                    end else begin
                        round_o      = RND_B0;
                        rnd_load_val = RND_B1;
                        state_d      = ST_PT_PERM;
                    end
                end
            end

            ST_PT_PERM: begin
                round_o        = rnd_q;
                en_reg_state_o = 1'b1;
                rnd_en         = !rnd_last;
                if (rnd_last) begin
                    blk_d   = blk_q + BLK_W'(1);
                    state_d = ST_WAIT_PT;
                end
            end

            ST_FINAL: begin
                round_o        = rnd_q;
                en_reg_state_o = 1'b1;
                rnd_en         = !rnd_last;
                if (rnd_last) begin
                    en_xor_key_o = 1'b1;
                    en_tag_o     = 1'b1;
                    state_d      = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// tb/tb_ascon_ctrl_fsm.sv - directed checks of the Ascon controller sequencing
module tb_ascon_ctrl_fsm;

    logic       clk = 1'b0;
    logic       resetb;
    logic       start [3];
    logic       valid [3];
    logic       ready [3];
    logic [3:0] rnd [3];
    logic       reg_en [3];
    logic       init_st [3];
    logic       xd [3];
    logic       kb [3];
    logic       xk [3];
    logic       lsb [3];
    logic       cipher [3];
    logic       tag [3];
    logic       done [3];

    int n_vec = 0;
    int n_err = 0;

    int cnt_reg, cnt_cipher, cnt_lsb, cnt_key, cnt_tag, cnt_ready;
    int first_key_n, lsb_n, lsb_round, both_n, tag_n, tag_key, kb_n, kb_round;
    int done_n, first_hs_cipher, stall_ok, resume_round;

    always #5 clk = ~clk;

    ascon_ctrl_fsm u_dut_def (
        .clock_i(clk), .resetb_i(resetb), .start_i(start[0]), .data_valid_i(valid[0]),
        .data_ready_o(ready[0]), .round_o(rnd[0]), .en_reg_state_o(reg_en[0]),
        .init_state_o(init_st[0]), .en_xor_data_o(xd[0]), .en_xor_key_begin_o(kb[0]),
        .en_xor_key_o(xk[0]), .en_xor_lsb_o(lsb[0]), .en_cipher_o(cipher[0]),
        .en_tag_o(tag[0]), .done_o(done[0])
    );

    ascon_ctrl_fsm #(.AD_BLOCKS(0)) u_dut_noad (
        .clock_i(clk), .resetb_i(resetb), .start_i(start[1]), .data_valid_i(valid[1]),
        .data_ready_o(ready[1]), .round_o(rnd[1]), .en_reg_state_o(reg_en[1]),
        .init_state_o(init_st[1]), .en_xor_data_o(xd[1]), .en_xor_key_begin_o(kb[1]),
        .en_xor_key_o(xk[1]), .en_xor_lsb_o(lsb[1]), .en_cipher_o(cipher[1]),
        .en_tag_o(tag[1]), .done_o(done[1])
    );

    ascon_ctrl_fsm #(.PT_BLOCKS(1)) u_dut_pt1 (
        .clock_i(clk), .resetb_i(resetb), .start_i(start[2]), .data_valid_i(valid[2]),
        .data_ready_o(ready[2]), .round_o(rnd[2]), .en_reg_state_o(reg_en[2]),
        .init_state_o(init_st[2]), .en_xor_data_o(xd[2]), .en_xor_key_begin_o(kb[2]),
        .en_xor_key_o(xk[2]), .en_xor_lsb_o(lsb[2]), .en_cipher_o(cipher[2]),
        .en_tag_o(tag[2]), .done_o(done[2])
    );

    task automatic check_vec(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [31:0] outvec(input int i);
        return {18'b0, ready[i], rnd[i], reg_en[i], init_st[i], xd[i], kb[i],
                xk[i], lsb[i], cipher[i], tag[i], done[i]};
    endfunction

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            valid[i] = 1'b0;
        end
        resetb = 1'b0;
        @(posedge clk);
        #1 resetb = 1'b1;
    endtask

    // Cycle n=0 is the first INIT round; returns once done_o is seen at a negedge.
    task automatic run_enc(input int idx, input int stall_from, input int stall_len,
                           input int start_at, input int bound);
        int  n;
        bit  seen_done;
        bit  first_hs;
        cnt_reg = 0; cnt_cipher = 0; cnt_lsb = 0; cnt_key = 0; cnt_tag = 0; cnt_ready = 0;
        first_key_n = -1; lsb_n = -1; lsb_round = -1; both_n = -1; tag_n = -1; tag_key = -1;
        kb_n = -1; kb_round = -1; done_n = -1; first_hs_cipher = -1; stall_ok = 0;
        resume_round = -1;
        @(posedge clk);
        #1 start[idx] = 1'b1;
        valid[idx] = 1'b1;
        @(posedge clk);
        #1 start[idx] = 1'b0;
        n = 0;
        seen_done = 1'b0;
        first_hs = 1'b1;
        while (!seen_done && n < bound) begin
            valid[idx] = !(n >= stall_from && n < stall_from + stall_len);
            start[idx] = (n == start_at);
            @(negedge clk);
            if (reg_en[idx]) cnt_reg++;
            if (cipher[idx]) cnt_cipher++;
            if (ready[idx]) cnt_ready++;
            if (tag[idx]) begin cnt_tag++; tag_n = n; tag_key = int'(xk[idx]); end
            if (lsb[idx]) begin cnt_lsb++; lsb_n = n; lsb_round = int'(rnd[idx]); end
            if (xk[idx]) begin
                cnt_key++;
                if (first_key_n < 0) first_key_n = n;
                if (lsb[idx]) both_n = n;
            end
            if (kb[idx]) begin kb_n = n; kb_round = int'(rnd[idx]); end
            if (ready[idx] && valid[idx] && first_hs) begin
                first_hs_cipher = int'(cipher[idx]);
                first_hs = 1'b0;
            end
            if (n >= stall_from && n < stall_from + stall_len && ready[idx] && !reg_en[idx])
                stall_ok++;
            if (stall_len > 0 && n == stall_from + stall_len) resume_round = int'(rnd[idx]);
            if (done[idx]) begin
                done_n = n;
                seen_done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        start[idx] = 1'b0;
        if (!seen_done) check_vec("run_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit found;
        do_reset();
        resetb = 1'b0;
        @(posedge clk);
        #1 resetb = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_vec($sformatf("reset_outs_%0d", i), outvec(i), 32'd0);

        // Reset in the middle of INIT, then a clean restart.
        @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (rnd[0] == 4'd5 && reg_en[0]) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check_vec("mid_init_reached", 32'(found), 32'd1);
        resetb = 1'b0;
        @(posedge clk);
        #1 resetb = 1'b1;
        valid[0] = 1'b1;
        @(negedge clk);
        check_vec("idle_after_reset", outvec(0), 32'd0);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        @(negedge clk);
        check_vec("restart_init_state", 32'(init_st[0]), 32'd1);
        check_vec("restart_round", 32'(rnd[0]), 32'd0);
        do_reset();

        // Defaults, zero stall, stray start during PT_PERM.
        run_enc(0, 1000, 0, 20, 200);
        check_vec("def_reg_cycles", 32'(cnt_reg), 32'd48);
        check_vec("def_cipher", 32'(cnt_cipher), 32'd4);
        check_vec("def_lsb_count", 32'(cnt_lsb), 32'd1);
        check_vec("def_lsb_cycle", 32'(lsb_n), 32'd17);
        check_vec("def_lsb_round", 32'(lsb_round), 32'd11);
        check_vec("def_key_count", 32'(cnt_key), 32'd2);
        check_vec("def_init_key", 32'(first_key_n), 32'd11);
        check_vec("def_kb_cycle", 32'(kb_n), 32'd36);
        check_vec("def_kb_round", 32'(kb_round), 32'd0);
        check_vec("def_tag_cycle", 32'(tag_n), 32'd47);
        check_vec("def_tag_with_key", 32'(tag_key), 32'd1);
        check_vec("def_tag_count", 32'(cnt_tag), 32'd1);
        check_vec("def_done_cycle", 32'(done_n), 32'd48);
        check_vec("def_ready_cycles", 32'(cnt_ready), 32'd5);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_vec("done_holds", outvec(0), 32'd1);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        @(negedge clk);
        check_vec("done_restart_done", 32'(done[0]), 32'd0);
        check_vec("done_restart_init", 32'(init_st[0]), 32'd1);
        check_vec("done_restart_round", 32'(rnd[0]), 32'd0);
        do_reset();

        // Source stalls three cycles on the first PT block.
        run_enc(0, 18, 3, -1, 200);
        check_vec("stall_ready_noreg", 32'(stall_ok), 32'd3);
        check_vec("stall_resume_round", 32'(resume_round), 32'd6);
        check_vec("stall_reg_cycles", 32'(cnt_reg), 32'd48);
        check_vec("stall_done_cycle", 32'(done_n), 32'd51);
        check_vec("stall_ready_cycles", 32'(cnt_ready), 32'd8);

        // No associated data.
        run_enc(1, 1000, 0, -1, 200);
        check_vec("noad_key_lsb_same", 32'(both_n), 32'd11);
        check_vec("noad_lsb_count", 32'(cnt_lsb), 32'd1);
        check_vec("noad_first_hs_pt", 32'(first_hs_cipher), 32'd1);
        check_vec("noad_reg_cycles", 32'(cnt_reg), 32'd42);
        check_vec("noad_done_cycle", 32'(done_n), 32'd42);
        check_vec("noad_ready_cycles", 32'(cnt_ready), 32'd4);

        // Single plaintext block.
        run_enc(2, 1000, 0, -1, 200);
        check_vec("pt1_kb_cycle", 32'(kb_n), 32'd18);
        check_vec("pt1_kb_round", 32'(kb_round), 32'd0);
        check_vec("pt1_final_rounds", 32'(tag_n - kb_n + 1), 32'd12);
        check_vec("pt1_cipher", 32'(cnt_cipher), 32'd1);
        check_vec("pt1_done_cycle", 32'(done_n), 32'd30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
